// File: rtl/display_mode_pkg.sv
// Register map, bit positions and FSM state type shared by the display mode controller.
package display_mode_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_REQ    = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_FLAGS  = 2'd3;

  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_SW_ONLY = 1;

  localparam int FLAG_COMMIT  = 0;
  localparam int FLAG_TIMEOUT = 1;

  localparam int STAT_PEND_LSB = 8;
  localparam int STAT_BUSY     = 16;
  localparam int STAT_DEB      = 17;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    APPLY   = 2'd2
  } state_e;

endpackage

// File: rtl/display_mode_debounce.sv
// Two-flop synchroniser, down-counting debouncer and registered rising-edge pulse
// for the board mode button.
module display_mode_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             rise_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter reloads whenever the input agrees with the debounced level, so any bounce restarts it.
  always_comb begin
    level_d = level_q;
    cnt_d   = CNT_LOAD;
    if (sync2_q != level_q) begin
      if (cnt_q == '0) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= CNT_LOAD;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/display_mode_ctrl.sv
// Display mode sequencer: button/software requests held pending and committed on vsync.
// Optional vsync wait timeout is built when DISPLAY_MODE_CTRL_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | no request outstanding
// PENDING | target latched, waiting for the next frame boundary
// APPLY   | one cycle: display_mode takes the pending target, commit flag set
module display_mode_ctrl
  import display_mode_pkg::*;
#(
  parameter int MODE_W          = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES  = 2000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mode_in,
  input  logic              vsync,
  input  logic [1:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [MODE_W-1:0] display_mode,
  output logic              mode_busy
);

  state_e            state_q, state_d;
  logic [MODE_W-1:0] pending_q, pending_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [1:0]        flags_q, flags_d;
  logic [31:0]       readdata_q, rd_d;

  logic              deb_level;
  logic              btn_rise;
  logic              sw_req;
  logic              btn_req;
  logic              req;
  logic [MODE_W-1:0] base;
  logic [MODE_W-1:0] target;
  logic              commit_set;
  logic              tmo_set;
  logic              tmo_hit;
  logic [1:0]        w1c;
  logic              unused_bits;

  display_mode_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_i  (mode_in),
    .level_o(deb_level),
    .rise_o (btn_rise)
  );

  // Button steps from the newest outstanding target; software wins a same-cycle collision.
  assign sw_req  = write && (address == ADDR_REQ);
  assign btn_req = btn_rise && !ctrl_q[CTRL_SW_ONLY];
  assign req     = sw_req || btn_req;
  assign base    = (state_q != IDLE) ? pending_q : mode_q;
  assign target  = sw_req ? writedata[MODE_W-1:0] : base + 1'b1;

`ifdef DISPLAY_MODE_CTRL_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Reloaded outside PENDING and on every overwrite, so it times only the current request.
  always_comb begin
    tmo_d = TMO_LOAD;
    if ((state_q == PENDING) && !req && (tmo_q != '0)) begin
      tmo_d = tmo_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= TMO_LOAD;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign tmo_hit = (state_q == PENDING) && (tmo_q == '0);
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    mode_d     = mode_q;
    commit_set = 1'b0;
    tmo_set    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          pending_d = target;
          state_d   = PENDING;
        end
      end
      PENDING: begin
        if (req) begin
          pending_d = target;
        end else if (vsync) begin
          state_d = APPLY;
        end else if (tmo_hit) begin
          state_d = APPLY;
          tmo_set = 1'b1;
        end
      end
      APPLY: begin
        mode_d     = pending_q;
        commit_set = 1'b1;
        if (req) begin
          pending_d = target;
          state_d   = PENDING;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Set beats a same-cycle write-1-to-clear.
  assign w1c     = (write && (address == ADDR_FLAGS)) ? writedata[1:0] : 2'b00;
  assign flags_d = (flags_q & ~w1c) | {tmo_set, commit_set};
  assign ctrl_d  = (write && (address == ADDR_CTRL)) ? writedata[1:0] : ctrl_q;

  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_STATUS: begin
        rd_d[MODE_W-1:0]               = mode_q;
        rd_d[STAT_PEND_LSB +: MODE_W]  = pending_q;
        rd_d[STAT_BUSY]                = (state_q != IDLE);
        rd_d[STAT_DEB]                 = deb_level;
      end
      ADDR_CTRL:  rd_d[1:0] = ctrl_q;
      ADDR_FLAGS: rd_d[1:0] = flags_q;
      default:    rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      mode_q     <= '0;
      ctrl_q     <= '0;
      flags_q    <= '0;
      readdata_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      ctrl_q    <= ctrl_d;
      flags_q   <= flags_d;
      if (read) begin
        readdata_q <= rd_d;
      end
    end
  end

  assign unused_bits  = ^{writedata, 32'(TIMEOUT_CYCLES)};

  assign readdata     = readdata_q;
  assign display_mode = mode_q;
  assign mode_busy    = (state_q != IDLE);
  assign irq          = ctrl_q[CTRL_IRQ_EN] & (|flags_q);

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Self-checking bench for display_mode_ctrl; expected reads and commits go through scoreboard queues.
`timescale 1ns/1ps
module tb_display_mode_ctrl;
  import display_mode_pkg::*;

  localparam int MODE_W = 2;
  localparam int DEB    = 8;
  localparam int TMO    = 100;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              mode_in = 1'b0;
  logic              vsync = 1'b0;
  logic [1:0]        address = '0;
  logic              read = 1'b0;
  logic              write = 1'b0;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic              irq;
  logic [MODE_W-1:0] display_mode;
  logic              mode_busy;

  int checks = 0;
  int errors = 0;

  logic [31:0]       rd_exp_q[$];
  logic [MODE_W-1:0] mode_exp_q[$];
  logic [31:0]       got_rd, exp_rd;
  logic [MODE_W-1:0] exp_m;

  always #5 clk = ~clk;

  display_mode_ctrl #(
    .MODE_W(MODE_W),
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .mode_in(mode_in),
    .vsync(vsync),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq),
    .display_mode(display_mode),
    .mode_busy(mode_busy)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sw_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick();
    write = 1'b0; writedata = '0;
  endtask

  task automatic start_read(input logic [1:0] a);
    address = a; read = 1'b1;
    tick();
    read = 1'b0;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  task automatic press_button();
    mode_in = 1'b1;
    tick(14);
    mode_in = 1'b0;
    tick(14);
  endtask

  function automatic logic [31:0] exp_status(input int m, input int p, input bit b, input bit d);
    logic [31:0] v;
    v = '0;
    v[MODE_W-1:0] = m[MODE_W-1:0];
    v[STAT_PEND_LSB +: MODE_W] = p[MODE_W-1:0];
    v[STAT_BUSY] = b;
    v[STAT_DEB] = d;
    return v;
  endfunction

  task automatic test_reset();
    logic [1:0] addrs [3];
    addrs[0] = ADDR_STATUS; addrs[1] = ADDR_CTRL; addrs[2] = ADDR_FLAGS;
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    checks++;
    if ({display_mode, mode_busy, irq} !== '0 || readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: mode=%0d busy=%0b irq=%0b rd=%h expected all 0", display_mode, mode_busy, irq, readdata);
    end
    for (int i = 0; i < 3; i++) begin
      rd_exp_q.push_back(32'h0);
      start_read(addrs[i]);
      got_rd = readdata; exp_rd = rd_exp_q.pop_front(); checks++;
      if (got_rd !== exp_rd) begin
        errors++;
        $display("FAIL reset_read addr%0d: got %h expected %h", i, got_rd, exp_rd);
      end
    end
  endtask

  task automatic test_debounce();
    bit busy_seen;
    busy_seen = 1'b0;
    repeat (3) begin
      mode_in = 1'b1;
      repeat (5) begin tick(); if (mode_busy) busy_seen = 1'b1; end
      mode_in = 1'b0;
      repeat (5) begin tick(); if (mode_busy) busy_seen = 1'b1; end
    end
    repeat (12) begin tick(); if (mode_busy) busy_seen = 1'b1; end
    checks++;
    if (busy_seen !== 1'b0) begin
      errors++;
      $display("FAIL dbn_glitch: busy_seen=%0b expected 0", busy_seen);
    end
    mode_in = 1'b1;
    tick(12);
    checks++;
    if (mode_busy !== 1'b1) begin
      errors++;
      $display("FAIL dbn_hold_busy: got %0b expected 1", mode_busy);
    end
    rd_exp_q.push_back(exp_status(0, 1, 1'b1, 1'b1));
    start_read(ADDR_STATUS);
    got_rd = readdata; exp_rd = rd_exp_q.pop_front(); checks++;
    if (got_rd !== exp_rd) begin
      errors++;
      $display("FAIL dbn_status: got %h expected %h", got_rd, exp_rd);
    end
    mode_in = 1'b0;
    tick(14);
    mode_exp_q.push_back(2'd1);
    pulse_vsync();
    checks++;
    if (display_mode !== 2'd0 || mode_busy !== 1'b1) begin
      errors++;
      $display("FAIL dbn_one_cycle_after_vsync: mode=%0d busy=%0b expected 0/1", display_mode, mode_busy);
    end
    tick();
    exp_m = mode_exp_q.pop_front(); checks++;
    if (display_mode !== exp_m || mode_busy !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL dbn_commit: mode=%0d busy=%0b irq=%0b expected %0d/0/0", display_mode, mode_busy, irq, exp_m);
    end
    rd_exp_q.push_back(32'h1);
    start_read(ADDR_FLAGS);
    got_rd = readdata; exp_rd = rd_exp_q.pop_front(); checks++;
    if (got_rd !== exp_rd) begin
      errors++;
      $display("FAIL dbn_flags: got %h expected %h", got_rd, exp_rd);
    end
    sw_write(ADDR_FLAGS, 32'h1);
  endtask

  task automatic test_wrap();
    mode_exp_q.push_back(2'd3);
    sw_write(ADDR_REQ, 32'd3);
    pulse_vsync();
    tick();
    exp_m = mode_exp_q.pop_front(); checks++;
    if (display_mode !== exp_m) begin
      errors++;
      $display("FAIL wrap_setup: mode=%0d expected %0d", display_mode, exp_m);
    end
    sw_write(ADDR_FLAGS, 32'h1);
    for (int i = 0; i < 2; i++) begin
      press_button();
      rd_exp_q.push_back(exp_status(3, (i == 0) ? 0 : 1, 1'b1, 1'b0));
      start_read(ADDR_STATUS);
      got_rd = readdata; exp_rd = rd_exp_q.pop_front(); checks++;
      if (got_rd !== exp_rd) begin
        errors++;
        $display("FAIL wrap_press%0d: got %h expected %h", i, got_rd, exp_rd);
      end
    end
    mode_exp_q.push_back(2'd1);
    pulse_vsync();
    tick();
    exp_m = mode_exp_q.pop_front(); checks++;
    if (display_mode !== exp_m) begin
      errors++;
      $display("FAIL wrap_commit: mode=%0d expected %0d", display_mode, exp_m);
    end
    sw_write(ADDR_FLAGS, 32'h1);
  endtask

  task automatic test_sw_priority();
    sw_write(ADDR_REQ, 32'd0);
    pulse_vsync();
    tick();
    sw_write(ADDR_FLAGS, 32'h1);
    // Debounced rise is presented to the FSM 11 edges after mode_in rises.
    mode_in = 1'b1;
    tick(10);
    sw_write(ADDR_REQ, 32'd2);
    tick(3);
    mode_in = 1'b0;
    tick(14);
    rd_exp_q.push_back(exp_status(0, 2, 1'b1, 1'b0));
    start_read(ADDR_STATUS);
    got_rd = readdata; exp_rd = rd_exp_q.pop_front(); checks++;
    if (got_rd !== exp_rd) begin
      errors++;
      $display("FAIL prio_same_cycle: got %h expected %h", got_rd, exp_rd);
    end
    sw_write(ADDR_CTRL, 32'h3);
    press_button();
    rd_exp_q.push_back(exp_status(0, 2, 1'b1, 1'b0));
    start_read(ADDR_STATUS);
    got_rd = readdata; exp_rd = rd_exp_q.pop_front(); checks++;
    if (got_rd !== exp_rd) begin
      errors++;
      $display("FAIL prio_sw_only: got %h expected %h", got_rd, exp_rd);
    end
    mode_exp_q.push_back(2'd2);
    pulse_vsync();
    tick();
    exp_m = mode_exp_q.pop_front(); checks++;
    if (display_mode !== exp_m || irq !== 1'b1) begin
      errors++;
      $display("FAIL prio_commit_irq: mode=%0d irq=%0b expected %0d/1", display_mode, irq, exp_m);
    end
    sw_write(ADDR_FLAGS, 32'h1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL prio_irq_clear: irq=%0b expected 0", irq);
    end
    sw_write(ADDR_CTRL, 32'h0);
  endtask

  task automatic test_boundary();
    address = ADDR_REQ; writedata = 32'd1; write = 1'b1; vsync = 1'b1;
    tick();
    write = 1'b0; vsync = 1'b0; writedata = '0;
    tick(3);
    checks++;
    if (display_mode !== 2'd2 || mode_busy !== 1'b1) begin
      errors++;
      $display("FAIL bnd_no_commit: mode=%0d busy=%0b expected 2/1", display_mode, mode_busy);
    end
    mode_exp_q.push_back(2'd1);
    pulse_vsync();
    address = ADDR_FLAGS; writedata = 32'h1; write = 1'b1;
    tick();
    write = 1'b0; writedata = '0;
    exp_m = mode_exp_q.pop_front(); checks++;
    if (display_mode !== exp_m) begin
      errors++;
      $display("FAIL bnd_next_vsync: mode=%0d expected %0d", display_mode, exp_m);
    end
    rd_exp_q.push_back(32'h1);
    start_read(ADDR_FLAGS);
    got_rd = readdata; exp_rd = rd_exp_q.pop_front(); checks++;
    if (got_rd !== exp_rd) begin
      errors++;
      $display("FAIL bnd_set_beats_w1c: got %h expected %h", got_rd, exp_rd);
    end
    sw_write(ADDR_FLAGS, 32'h1);
    rd_exp_q.push_back(32'h0);
    start_read(ADDR_REQ);
    got_rd = readdata; exp_rd = rd_exp_q.pop_front(); checks++;
    if (got_rd !== exp_rd) begin
      errors++;
      $display("FAIL bnd_req_reads_0: got %h expected %h", got_rd, exp_rd);
    end
    address = ADDR_STATUS; read = 1'b1;
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL bnd_read_early: got %h expected 0", readdata);
    end
    tick();
    read = 1'b0;
    rd_exp_q.push_back(exp_status(1, 1, 1'b0, 1'b0));
    got_rd = readdata; exp_rd = rd_exp_q.pop_front(); checks++;
    if (got_rd !== exp_rd) begin
      errors++;
      $display("FAIL bnd_read_latency: got %h expected %h", got_rd, exp_rd);
    end
    tick(2);
    checks++;
    if (readdata !== exp_rd) begin
      errors++;
      $display("FAIL bnd_read_hold: got %h expected %h", readdata, exp_rd);
    end
  endtask

  task automatic test_timeout();
    sw_write(ADDR_REQ, 32'd3);
`ifdef DISPLAY_MODE_CTRL_TIMEOUT_EN
    begin
      int n;
      n = 0;
      while (mode_busy && n < TMO + 20) begin
        tick();
        n++;
      end
      checks++;
      if (n !== TMO + 1 || display_mode !== 2'd3) begin
        errors++;
        $display("FAIL tmo_commit: cycles=%0d mode=%0d expected %0d/3", n, display_mode, TMO + 1);
      end
      rd_exp_q.push_back(32'h3);
    end
`else
    tick(1000);
    checks++;
    if (mode_busy !== 1'b1 || display_mode !== 2'd1) begin
      errors++;
      $display("FAIL tmo_wait_forever: busy=%0b mode=%0d expected 1/1", mode_busy, display_mode);
    end
    mode_exp_q.push_back(2'd3);
    pulse_vsync();
    tick();
    exp_m = mode_exp_q.pop_front(); checks++;
    if (display_mode !== exp_m) begin
      errors++;
      $display("FAIL tmo_vsync_commit: mode=%0d expected %0d", display_mode, exp_m);
    end
    rd_exp_q.push_back(32'h1);
`endif
    start_read(ADDR_FLAGS);
    got_rd = readdata; exp_rd = rd_exp_q.pop_front(); checks++;
    if (got_rd !== exp_rd) begin
      errors++;
      $display("FAIL tmo_flags: got %h expected %h", got_rd, exp_rd);
    end
    sw_write(ADDR_FLAGS, 32'h3);
  endtask

  task automatic test_async_reset();
    sw_write(ADDR_CTRL, 32'h1);
    sw_write(ADDR_REQ, 32'd2);
    pulse_vsync();
    tick();
    sw_write(ADDR_REQ, 32'd1);
    start_read(ADDR_STATUS);
    checks++;
    if (irq !== 1'b1 || mode_busy !== 1'b1 || readdata !== exp_status(2, 1, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL arst_precondition: irq=%0b busy=%0b rd=%h", irq, mode_busy, readdata);
    end
    #1;
    reset_n = 1'b0;
    #2;
    checks++;
    if (display_mode !== '0 || mode_busy !== 1'b0 || irq !== 1'b0 || readdata !== 32'h0) begin
      errors++;
      $display("FAIL arst_immediate: mode=%0d busy=%0b irq=%0b rd=%h expected all 0", display_mode, mode_busy, irq, readdata);
    end
    tick(2);
    reset_n = 1'b1;
    tick(2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_debounce();
    test_wrap();
    test_sw_priority();
    test_boundary();
    test_timeout();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
